seg_scan_to_num: RTL and testbench

- Receive side of the seven-segment display drive: snoops a multiplexed display bus (shared active-low segments + decimal point, active-low one-hot digit enables).
- Waits for each digit's drive to be stable, captures it, and maps the pattern back to a 4-bit number.
- Once every digit has been seen, publishes a complete frame.
- Used as a self-check monitor and a loop-back decoder beside the display driver.

---
 rtl/seg_scan_to_num_pkg.sv | 30 +++
 rtl/seg_scan_to_num_if.sv | 24 ++
 rtl/seg_scan_to_num_seg_to_num.sv | 37 +++
 rtl/seg_scan_to_num.sv | 186 ++++++++++++++++++
 tb/tb_seg_scan_to_num.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_to_num_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph patterns, special
// number codes and the capture FSM state encoding.
package seg_scan_pkg;

    // Patterns are written g..a, i.e. seg7[6:0], active-low.
    localparam logic [6:0] PAT_0     = 7'b1000000;
    localparam logic [6:0] PAT_1     = 7'b1111001;
    localparam logic [6:0] PAT_2     = 7'b0100100;
    localparam logic [6:0] PAT_3     = 7'b0110000;
    localparam logic [6:0] PAT_4     = 7'b0011001;
    localparam logic [6:0] PAT_5     = 7'b0010010;
    localparam logic [6:0] PAT_6     = 7'b0000010;
    localparam logic [6:0] PAT_7     = 7'b1111000;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0010000;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;
    // The driver's error code reuses the "0" glyph and is told apart by a lit dp.
    localparam logic [6:0] PAT_ERR   = PAT_0;

    localparam logic [3:0] NUM_BLANK = 4'hE;
    localparam logic [3:0] NUM_ERR   = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/seg_scan_to_num_if.sv
// Display-bus snoop interface: the multiplexed segment bus going in and the
// decoded frame coming out.
interface seg_scan_to_num_if #(
    parameter int N_DIG = 4
);
    logic [N_DIG-1:0]   an;
    logic [6:0]         seg7;
    logic               dpt;
    logic [4*N_DIG-1:0] nums;
    logic [N_DIG-1:0]   dpts;
    logic [N_DIG-1:0]   dig_err;
    logic               frame_valid;
    logic               an_err;

    modport master (
        output an, seg7, dpt,
        input  nums, dpts, dig_err, frame_valid, an_err
    );

    modport slave (
        input  an, seg7, dpt,
        output nums, dpts, dig_err, frame_valid, an_err
    );
endinterface

// File: rtl/seg_scan_to_num_seg_to_num.sv
// Combinational reverse lookup from an active-low seven-segment pattern (plus
// decimal point) to a 4-bit number and an error flag.
module seg_to_num
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_seg7,
    input  logic       i_dpt,
    output logic [3:0] o_num,
    output logic       o_err
);

    always_comb begin
        o_num = NUM_ERR;
        o_err = 1'b1;
        case (i_seg7)
            PAT_0: begin
                // With the dp lit this glyph is the error code, so keep the defaults.
                if (i_dpt) begin
                    o_num = 4'd0;
                    o_err = 1'b0;
                end
            end
            PAT_1:     begin o_num = 4'd1;      o_err = 1'b0; end
            PAT_2:     begin o_num = 4'd2;      o_err = 1'b0; end
            PAT_3:     begin o_num = 4'd3;      o_err = 1'b0; end
            PAT_4:     begin o_num = 4'd4;      o_err = 1'b0; end
            PAT_5:     begin o_num = 4'd5;      o_err = 1'b0; end
            PAT_6:     begin o_num = 4'd6;      o_err = 1'b0; end
            PAT_7:     begin o_num = 4'd7;      o_err = 1'b0; end
            PAT_8:     begin o_num = 4'd8;      o_err = 1'b0; end
            PAT_9:     begin o_num = 4'd9;      o_err = 1'b0; end
            PAT_BLANK: begin o_num = NUM_BLANK; o_err = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg_scan_to_num.sv
// Snoops a multiplexed seven-segment display bus, captures each digit once its
// drive has been stable long enough, and publishes a full decoded frame.
module seg_scan_to_num
    import seg_scan_pkg::*;
#(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_to_num_if.slave io_bus
);

    localparam int                 BW       = N_DIG + 8;
    localparam logic [7:0]         CNT_LAST = 8'(STABLE_CYC - 1);
    localparam logic [7:0]         CNT_MAX  = 8'(STABLE_CYC);
    localparam logic [N_DIG-1:0]   LSB_ONE  = N_DIG'(1);

    logic [BW-1:0]      w_bus_in;
    logic [BW-1:0]      r_bus;
    logic [BW-1:0]      r_bus_d;
    logic [N_DIG-1:0]   w_an;
    logic [N_DIG-1:0]   w_an_low;
    logic [6:0]         w_seg7;
    logic               w_dpt;
    logic               w_same;
    logic               w_one_hot;
    logic               w_multi;
    logic [3:0]         w_num;
    logic               w_err;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [N_DIG-1:0]   r_cand_mask;
    logic [3:0]         r_cand_num;
    logic               r_cand_dpt;
    logic               r_cand_err;
    logic [N_DIG-1:0]   r_captured;
    logic [4*N_DIG-1:0] r_sh_nums;
    logic [N_DIG-1:0]   r_sh_dpts;
    logic [N_DIG-1:0]   r_sh_err;
    logic [4*N_DIG-1:0] w_sh_nums_nx;
    logic [N_DIG-1:0]   w_sh_dpts_nx;
    logic [N_DIG-1:0]   w_sh_err_nx;
    logic [4*N_DIG-1:0] r_nums;
    logic [N_DIG-1:0]   r_dpts;
    logic [N_DIG-1:0]   r_dig_err;
    logic               r_fv;
    logic               r_an_err;

    assign w_bus_in = {io_bus.an, io_bus.seg7, io_bus.dpt};
    assign w_an     = r_bus[BW-1:8];
    assign w_seg7   = r_bus[7:1];
    assign w_dpt    = r_bus[0];
    assign w_same   = (r_bus == r_bus_d);

    assign w_an_low  = ~w_an;
    assign w_one_hot = (w_an_low != '0) && ((w_an_low & (w_an_low - LSB_ONE)) == '0);
    assign w_multi   = (w_an_low != '0) && !w_one_hot;

    seg_to_num u_seg_to_num (
        .i_seg7 (w_seg7),
        .i_dpt  (w_dpt),
        .o_num  (w_num),
        .o_err  (w_err)
    );

    // Shadow buffer as it will look once the pending candidate is written in.
    always_comb begin
        w_sh_nums_nx = r_sh_nums;
        w_sh_dpts_nx = r_sh_dpts;
        w_sh_err_nx  = r_sh_err;
        for (int i = 0; i < N_DIG; i++) begin
            if (r_cand_mask[i]) begin
                w_sh_nums_nx[4*i +: 4] = r_cand_num;
                w_sh_dpts_nx[i]        = r_cand_dpt;
                w_sh_err_nx[i]         = r_cand_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Input copies reset to the idle bus level so reset never looks like a multi-hot an.
            r_bus       <= '1;
            r_bus_d     <= '1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand_mask <= '0;
            r_cand_num  <= '0;
            r_cand_dpt  <= 1'b0;
            r_cand_err  <= 1'b0;
            r_captured  <= '0;
            r_sh_nums   <= '0;
            r_sh_dpts   <= '0;
            r_sh_err    <= '0;
            r_nums      <= '0;
            r_dpts      <= '0;
            r_dig_err   <= '0;
            r_fv        <= 1'b0;
            r_an_err    <= 1'b0;
        end else begin
            r_bus   <= w_bus_in;
            r_bus_d <= r_bus;
            r_fv    <= 1'b0;

            if (w_multi) begin
                r_an_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_one_hot) begin
                        r_state <= SETTLE;
                        r_cnt   <= 8'd1;
                    end
                end

                SETTLE: begin
                    if (!w_same) begin
                        if (w_one_hot) begin
                            r_cnt <= 8'd1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_cnt >= CNT_LAST) begin
                        r_cnt       <= CNT_MAX;
                        r_state     <= CAPTURE;
                        r_cand_mask <= w_an_low;
                        r_cand_num  <= w_num;
                        r_cand_dpt  <= w_dpt;
                        r_cand_err  <= w_err;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                CAPTURE: begin
                    r_sh_nums <= w_sh_nums_nx;
                    r_sh_dpts <= w_sh_dpts_nx;
                    r_sh_err  <= w_sh_err_nx;
                    if ((r_captured | r_cand_mask) == '1) begin
                        r_nums     <= w_sh_nums_nx;
                        r_dpts     <= w_sh_dpts_nx;
                        r_dig_err  <= w_sh_err_nx;
                        r_fv       <= 1'b1;
                        r_captured <= '0;
                    end else begin
                        r_captured <= r_captured | r_cand_mask;
                    end
                    // A bus change already visible here must not be lost to HOLD.
                    if (!w_same) begin
                        if (w_one_hot) begin
                            r_state <= SETTLE;
                            r_cnt   <= 8'd1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= HOLD;
                    end
                end

                HOLD: begin
                    if (!w_same) begin
                        if (w_one_hot) begin
                            r_state <= SETTLE;
                            r_cnt   <= 8'd1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.nums        = r_nums;
    assign io_bus.dpts        = r_dpts;
    assign io_bus.dig_err     = r_dig_err;
    assign io_bus.frame_valid = r_fv;
    assign io_bus.an_err      = r_an_err;

endmodule

// File: tb/tb_seg_scan_to_num.sv
// Bench for seg_scan_to_num: directed display scans followed by random dwells,
// compared cycle by cycle against a run-length reference model.
module tb_seg_scan_to_num;

    localparam int N_DIG      = 4;
    localparam int STABLE_CYC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_to_num_if #(.N_DIG(N_DIG)) bus_if ();

    seg_scan_to_num #(
        .N_DIG      (N_DIG),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int fv_seen = 0;

    logic [6:0] glyph [10];

    // Reference model state
    logic [N_DIG+7:0]   prev_smp;
    int                 run_len;
    logic [3:0]         m_num [N_DIG];
    logic               m_dpt [N_DIG];
    logic               m_err [N_DIG];
    logic [N_DIG-1:0]   m_cap;
    int                 pub_cnt;
    logic [4*N_DIG-1:0] pend_nums;
    logic [N_DIG-1:0]   pend_dpts;
    logic [N_DIG-1:0]   pend_err;
    logic               multi_prev;
    logic [4*N_DIG-1:0] exp_nums;
    logic [N_DIG-1:0]   exp_dpts;
    logic [N_DIG-1:0]   exp_err;
    logic               exp_fv;
    logic               exp_an_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] s, input logic d,
                                       output logic [3:0] n, output logic e);
        n = 4'hF;
        e = 1'b1;
        if (s == 7'b1111111) begin
            n = 4'hE;
            e = 1'b0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (s == glyph[i] && !(i == 0 && !d)) begin
                    n = 4'(i);
                    e = 1'b0;
                end
            end
        end
    endfunction

    task automatic model_reset();
        prev_smp   = '1;
        run_len    = 0;
        m_cap      = '0;
        pub_cnt    = 0;
        multi_prev = 1'b0;
        exp_nums   = '0;
        exp_dpts   = '0;
        exp_err    = '0;
        exp_fv     = 1'b0;
        exp_an_err = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            m_num[i] = '0;
            m_dpt[i] = 1'b0;
            m_err[i] = 1'b0;
        end
    endtask

    // One clock edge of the model, with the bus value sampled at that edge.
    task automatic model_edge(input logic [N_DIG-1:0] a, input logic [6:0] s, input logic d);
        logic [N_DIG+7:0] smp;
        int lows;
        int slot;
        logic [3:0] n;
        logic e;
        exp_fv = 1'b0;
        if (pub_cnt > 0) begin
            pub_cnt--;
            if (pub_cnt == 0) begin
                exp_nums = pend_nums;
                exp_dpts = pend_dpts;
                exp_err  = pend_err;
                exp_fv   = 1'b1;
            end
        end
        if (multi_prev) exp_an_err = 1'b1;
        smp = {a, s, d};
        run_len = (smp == prev_smp) ? run_len + 1 : 1;
        prev_smp = smp;
        lows = 0;
        slot = 0;
        for (int i = 0; i < N_DIG; i++) begin
            if (!a[i]) begin
                lows++;
                slot = i;
            end
        end
        multi_prev = (lows > 1);
        if (lows == 1 && run_len == STABLE_CYC) begin
            ref_decode(s, d, n, e);
            m_num[slot] = n;
            m_dpt[slot] = d;
            m_err[slot] = e;
            m_cap[slot] = 1'b1;
            if (&m_cap) begin
                for (int i = 0; i < N_DIG; i++) begin
                    pend_nums[4*i +: 4] = m_num[i];
                    pend_dpts[i]        = m_dpt[i];
                    pend_err[i]         = m_err[i];
                end
                pub_cnt = 2;
                m_cap   = '0;
            end
        end
    endtask

    task automatic step(input logic [N_DIG-1:0] a, input logic [6:0] s, input logic d);
        bus_if.an   = a;
        bus_if.seg7 = s;
        bus_if.dpt  = d;
        @(posedge clk);
        #1;
        model_edge(a, s, d);
        if (bus_if.frame_valid) fv_seen++;
        check("frame_valid", 32'(bus_if.frame_valid), 32'(exp_fv));
        check("an_err",      32'(bus_if.an_err),      32'(exp_an_err));
        check("nums",        32'(bus_if.nums),        32'(exp_nums));
        check("dpts",        32'(bus_if.dpts),        32'(exp_dpts));
        check("dig_err",     32'(bus_if.dig_err),     32'(exp_err));
    endtask

    task automatic dwell(input int slot, input logic [6:0] s, input logic d, input int len);
        logic [N_DIG-1:0] a;
        a = '1;
        a[slot] = 1'b0;
        repeat (len) step(a, s, d);
    endtask

    task automatic idle(input int len);
        repeat (len) step('1, 7'b1111111, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_nums"},    32'(bus_if.nums),        32'h0);
        check({tag, "_dpts"},    32'(bus_if.dpts),        32'h0);
        check({tag, "_dig_err"}, 32'(bus_if.dig_err),     32'h0);
        check({tag, "_fv"},      32'(bus_if.frame_valid), 32'h0);
        check({tag, "_an_err"},  32'(bus_if.an_err),      32'h0);
    endtask

    task automatic do_reset(input int len);
        rst_n = 1'b0;
        bus_if.an   = '1;
        bus_if.seg7 = 7'b1111111;
        bus_if.dpt  = 1'b1;
        model_reset();
        repeat (len) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic frame_check(input string tag, input logic [15:0] n, input logic [3:0] dp,
                               input logic [3:0] er, input logic ae);
        check({tag, "_nums"},    32'(bus_if.nums),    32'(n));
        check({tag, "_dpts"},    32'(bus_if.dpts),    32'(dp));
        check({tag, "_dig_err"}, 32'(bus_if.dig_err), 32'(er));
        check({tag, "_an_err"},  32'(bus_if.an_err),  32'(ae));
        check({tag, "_frames"},  32'(fv_seen),        32'd1);
    endtask

    initial begin
        logic [N_DIG-1:0] a;
        logic [6:0]       s;
        logic             d;
        int               sel;
        int               i0;
        int               j0;

        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;

        rst_n = 1'b0;
        bus_if.an   = '1;
        bus_if.seg7 = 7'b1111111;
        bus_if.dpt  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;
        idle(2);

        // Plain scan of 3,1,4,1
        fv_seen = 0;
        dwell(0, glyph[3], 1'b1, 6);
        dwell(1, glyph[1], 1'b1, 6);
        dwell(2, glyph[4], 1'b1, 6);
        dwell(3, glyph[1], 1'b1, 6);
        idle(3);
        frame_check("scan3141", 16'h1413, 4'hF, 4'h0, 1'b0);

        // Error code on slot 2
        fv_seen = 0;
        dwell(0, glyph[7], 1'b1, 6);
        dwell(1, glyph[7], 1'b1, 6);
        dwell(2, glyph[0], 1'b0, 6);
        dwell(3, glyph[7], 1'b1, 6);
        idle(3);
        frame_check("errcode", 16'h7F77, 4'b1011, 4'b0100, 1'b0);

        // Short dwell on slot 1 captures nothing
        fv_seen = 0;
        dwell(0, glyph[0], 1'b1, 6);
        dwell(1, glyph[3], 1'b1, 3);
        dwell(2, glyph[2], 1'b1, 6);
        dwell(3, glyph[8], 1'b1, 6);
        idle(3);
        check("short_no_frame", 32'(fv_seen), 32'd0);
        dwell(1, glyph[5], 1'b1, 6);
        idle(3);
        frame_check("short", 16'h8250, 4'hF, 4'h0, 1'b0);

        // Unknown glyph and blank
        fv_seen = 0;
        dwell(0, 7'b1011111, 1'b1, 6);
        dwell(1, glyph[1], 1'b1, 6);
        dwell(2, glyph[2], 1'b1, 6);
        dwell(3, 7'b1111111, 1'b1, 6);
        idle(3);
        frame_check("blank", 16'hE21F, 4'hF, 4'b0001, 1'b0);

        // Multi-hot an mid-scan
        fv_seen = 0;
        dwell(0, glyph[1], 1'b1, 6);
        dwell(1, glyph[2], 1'b1, 6);
        repeat (2) step(4'b1100, glyph[8], 1'b1);
        dwell(2, glyph[3], 1'b1, 6);
        dwell(3, glyph[4], 1'b1, 6);
        idle(3);
        frame_check("multihot", 16'h4321, 4'hF, 4'h0, 1'b1);

        // Reset after two captures, then a clean scan
        dwell(0, glyph[5], 1'b1, 6);
        dwell(1, glyph[5], 1'b0, 6);
        dwell(2, glyph[5], 1'b1, 2);
        do_reset(2);
        fv_seen = 0;
        dwell(0, glyph[9], 1'b1, 6);
        dwell(1, glyph[8], 1'b1, 6);
        dwell(2, glyph[7], 1'b1, 6);
        dwell(3, glyph[6], 1'b1, 6);
        idle(3);
        frame_check("postreset", 16'h6789, 4'hF, 4'h0, 1'b0);

        // Random dwells
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 19);
            a = '1;
            if (sel == 0) begin
                a = '1;
            end else if (sel == 1) begin
                i0 = $urandom_range(0, N_DIG - 1);
                j0 = (i0 + 1 + $urandom_range(0, N_DIG - 2)) % N_DIG;
                a[i0] = 1'b0;
                a[j0] = 1'b0;
            end else begin
                a[$urandom_range(0, N_DIG - 1)] = 1'b0;
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      s = 7'b1111111;
            else if (sel == 1) s = 7'($urandom);
            else               s = glyph[$urandom_range(0, 9)];
            d = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(1, 8)) step(a, s, d);
            if (k == 150) do_reset(1);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
